// File: rtl/adapter_ul_pack.sv
// Uplink sample packer: collects eight 32-bit {Q,I} DDC words into the 8-lane
// parallel I/Q buses used by the UTRA-FDD block, with frame alignment and gap timeout.
module adapter_ul_pack #(
    parameter int IQ_BIT_WIDTH   = 16,
    parameter int GAP_TIMEOUT    = 16,
    parameter bit ALIGN_ON_START = 1'b1
) (
    input  logic                      clk_1,
    input  logic                      rst,
    input  logic                      ddc_data_valid,
    input  logic [31:0]               ddc_data,
    input  logic                      ddc_frame_start,
    output logic [8*IQ_BIT_WIDTH-1:0] iq_tx_i,
    output logic [8*IQ_BIT_WIDTH-1:0] iq_tx_q,
    output logic                      iq_tx_data_valid,
    output logic                      align_err,
    output logic                      timeout_err,
    output logic [15:0]               block_count
);

    localparam int         W        = IQ_BIT_WIDTH;
    localparam logic [7:0] GAP_LAST = 8'(GAP_TIMEOUT - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        FILL   = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [2:0]          lane_cnt, lane_nxt;
    logic [7:0]          gap_cnt, gap_nxt;
    logic [6:0][W-1:0]   stage_i;
    logic [6:0][W-1:0]   stage_q;

    logic [W-1:0] sample_i;
    logic [W-1:0] sample_q;

    logic       wr_en;
    logic [2:0] wr_lane;
    logic       emit;
    logic       align_hit;
    logic       timeout_hit;

    // At 15 bits the top bit of each half-word is simply not selected.
    assign sample_i = ddc_data[W-1:0];
    assign sample_q = ddc_data[16 +: W];

    // State register.
    always_ff @(posedge clk_1) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= SEARCH;
            lane_cnt <= 3'd0;
            gap_cnt  <= 8'd0;
        end else begin
            state    <= state_nxt;
            lane_cnt <= lane_nxt;
            gap_cnt  <= gap_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: if (wr_en)       state_nxt = FILL;
            FILL:   if (timeout_hit) state_nxt = SEARCH;
            default:                 state_nxt = SEARCH;
        endcase
    end

    // Action decode: which lane is written, and which events fire this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        wr_en       = 1'b0;
        wr_lane     = 3'd0;
        emit        = 1'b0;
        align_hit   = 1'b0;
        timeout_hit = 1'b0;
        lane_nxt    = lane_cnt;
        gap_nxt     = gap_cnt;
        case (state)
            SEARCH: begin
                gap_nxt = 8'd0;
                if (ddc_data_valid && (ddc_frame_start || !ALIGN_ON_START)) begin
                    wr_en    = 1'b1;
                    lane_nxt = 3'd1;
                end
            end
            FILL: begin
                if (ddc_data_valid) begin
                    gap_nxt = 8'd0;
                    wr_en   = 1'b1;
                    if (ddc_frame_start && lane_cnt != 3'd0) begin
                        align_hit = 1'b1;
                        lane_nxt  = 3'd1;
                    end else begin
                        wr_lane  = lane_cnt;
                        lane_nxt = lane_cnt + 3'd1;
                        emit     = (lane_cnt == 3'd7);
                    end
                end else if (lane_cnt != 3'd0) begin
                    // A valid word in the limit cycle takes the branch above instead.
                    if (gap_cnt == GAP_LAST) begin
                        timeout_hit = 1'b1;
                        lane_nxt    = 3'd0;
                        gap_nxt     = 8'd0;
                    end else begin
                        gap_nxt = gap_cnt + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Staging lanes and registered outputs.
    always_ff @(posedge clk_1) begin
        if (rst) begin
            // NOTE: the staging lanes are reset even though every emitted block
            // overwrites all of them; this keeps the post-reset contents defined.
            stage_i          <= '0;
            stage_q          <= '0;
            iq_tx_i          <= '0;
            iq_tx_q          <= '0;
            iq_tx_data_valid <= 1'b0;
            align_err        <= 1'b0;
            timeout_err      <= 1'b0;
            block_count      <= 16'd0;
        end else begin
            iq_tx_data_valid <= emit;
            align_err        <= align_hit;
            timeout_err      <= timeout_hit;
            for (int k = 0; k < 7; k++) begin
                if (wr_en && wr_lane == 3'(k)) begin
                    stage_i[k] <= sample_i;
                    stage_q[k] <= sample_q;
                end
            end
            // Lane 7 bypasses staging and comes straight from the current word.
            if (emit) begin
                iq_tx_i     <= {sample_i, stage_i};
                iq_tx_q     <= {sample_q, stage_q};
                block_count <= block_count + 16'd1;
            end
        end
    end

endmodule
